decode_stage: RTL

- Decode/operand-fetch stage directly downstream of the instruction fetch stage of processor Z.
- Consumes the fields the fetch stage produces (icode, ifun, rA, rB, valC) through a valid/ready handshake.
- Reads operands from an internal 15-entry register file, and uses a per-register scoreboard to interlock against results that have not yet been written back.
- Presents one decoded instruction per cycle to the execute stage.

---
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Signal bundle between fetch, decode_stage, execute and write-back.
// The bench drives the master side and decode_stage is the slave.
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int VALC_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [VALC_W-1:0] valC;
  logic              wb_en;
  logic [3:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_icode;
  logic [3:0]        out_ifun;
  logic [DATA_W-1:0] out_valA;
  logic [DATA_W-1:0] out_valB;
  logic [DATA_W-1:0] out_valC;
  logic [3:0]        out_dstE;
  logic              out_err;
  logic              halted;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, wb_en, wb_dst, wb_data, out_ready,
    input  in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB, out_valC,
           out_dstE, out_err, halted
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, wb_en, wb_dst, wb_data, out_ready,
    output in_ready, out_valid, out_icode, out_ifun, out_valA, out_valB, out_valC,
           out_dstE, out_err, halted
  );
endinterface

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: 15-entry register file, per-register scoreboard
// interlock with write-back bypass, and a one-deep registered output to execute.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int VALC_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  decode_stage_if.slave bus
);
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] IC_HALT  = 4'h0;
  localparam logic [3:0] IC_NOP   = 4'h1;
  localparam logic [3:0] IC_RRMOV = 4'h2;
  localparam logic [3:0] IC_IRMOV = 4'h3;
  localparam logic [3:0] IC_OP    = 4'h6;

  typedef struct packed {
    logic              blk;
    logic [DATA_W-1:0] val;
  } operand_t;

  // A same-cycle write-back both supplies the value and lifts the interlock.
  function automatic operand_t fetch_operand(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf [15],
    input logic [14:0]       sb,
    input logic              wb_en,
    input logic [3:0]        wb_dst,
    input logic [DATA_W-1:0] wb_data
  );
    operand_t op;
    op = '0;
    if (src == REG_NONE) begin
      op = '0;
    end else if (wb_en && (wb_dst == src)) begin
      op.val = wb_data;
    end else begin
      op.val = rf[src];
      op.blk = sb[src];
    end
    return op;
  endfunction

  logic [DATA_W-1:0] rf_r [15];
  logic [14:0]       sb_r;
  logic [14:0]       sb_next_s;
  logic [14:0]       clr_mask_s;
  logic [14:0]       set_mask_s;
  logic [3:0]        src_a_s;
  logic [3:0]        src_b_s;
  logic [3:0]        dst_s;
  logic              err_s;
  operand_t          op_a_s;
  operand_t          op_b_s;
  logic              ready_s;
  logic              accept_s;
  logic              wb_write_s;

  logic              out_valid_r;
  logic [3:0]        out_icode_r;
  logic [3:0]        out_ifun_r;
  logic [DATA_W-1:0] out_valA_r;
  logic [DATA_W-1:0] out_valB_r;
  logic [DATA_W-1:0] out_valC_r;
  logic [3:0]        out_dstE_r;
  logic              out_err_r;
  logic              halted_r;

  // Source/destination selection by instruction code.
  always_comb begin
    src_a_s = REG_NONE;
    src_b_s = REG_NONE;
    dst_s   = REG_NONE;
    err_s   = 1'b0;
    case (bus.icode)
      IC_HALT, IC_NOP: dst_s = REG_NONE;
      IC_RRMOV: begin
        src_a_s = bus.rA;
        dst_s   = bus.rB;
      end
      IC_IRMOV: dst_s = bus.rB;
      IC_OP: begin
        src_a_s = bus.rA;
        src_b_s = bus.rB;
        dst_s   = bus.rB;
      end
      default: err_s = 1'b1;
    endcase
  end

  // Operand read, interlock, handshake and scoreboard next state.
  always_comb begin
    op_a_s     = fetch_operand(src_a_s, rf_r, sb_r, bus.wb_en, bus.wb_dst, bus.wb_data);
    op_b_s     = fetch_operand(src_b_s, rf_r, sb_r, bus.wb_en, bus.wb_dst, bus.wb_data);
    ready_s    = !halted_r && !op_a_s.blk && !op_b_s.blk && (!out_valid_r || bus.out_ready);
    accept_s   = bus.in_valid && ready_s;
    wb_write_s = bus.wb_en && (bus.wb_dst != REG_NONE);
    clr_mask_s = wb_write_s ? (15'd1 << bus.wb_dst) : 15'd0;
    set_mask_s = (accept_s && (dst_s != REG_NONE)) ? (15'd1 << dst_s) : 15'd0;
    sb_next_s  = (sb_r & ~clr_mask_s) | set_mask_s;
  end

  // Register file and scoreboard state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) begin
        rf_r[i] <= '0;
      end
      sb_r <= 15'd0;
    end else begin
      sb_r <= sb_next_s;
      if (wb_write_s) begin
        rf_r[bus.wb_dst] <= bus.wb_data;
      end
    end
  end

  // Output register towards execute, plus the sticky halt flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_icode_r <= 4'h0;
      out_ifun_r  <= 4'h0;
      out_valA_r  <= '0;
      out_valB_r  <= '0;
      out_valC_r  <= '0;
      out_dstE_r  <= REG_NONE;
      out_err_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_icode_r <= bus.icode;
      out_ifun_r  <= bus.ifun;
      out_valA_r  <= op_a_s.val;
      out_valB_r  <= op_b_s.val;
      out_valC_r  <= {{(DATA_W-VALC_W){bus.valC[VALC_W-1]}}, bus.valC};
      out_dstE_r  <= dst_s;
      out_err_r   <= err_s;
      halted_r    <= halted_r || (bus.icode == IC_HALT);
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_icode = out_icode_r;
  assign bus.out_ifun  = out_ifun_r;
  assign bus.out_valA  = out_valA_r;
  assign bus.out_valB  = out_valB_r;
  assign bus.out_valC  = out_valC_r;
  assign bus.out_dstE  = out_dstE_r;
  assign bus.out_err   = out_err_r;
  assign bus.halted    = halted_r;
endmodule
